dual_avg_sequencer: RTL and testbench

//  Sequencer for the shared avg datapath (16x16 reg file, op/src1/src2/dest, overflow).
//  Two sample channels share one datapath; block arbitrates round-robin, then issues the
//  op sequence that shifts the channel's 4-sample window and sums it into R0.

---
 rtl/dual_avg_sequencer_pkg.sv | 35 +++
 rtl/dual_avg_sequencer_if.sv | 23 ++
 rtl/dual_avg_sequencer_dr_capture.sv | 37 +++
 rtl/dual_avg_sequencer.sv | 156 +++++++++++++++
 tb/tb_dual_avg_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dual_avg_sequencer_pkg.sv
// Shared types for the dual-channel averaging sequencer: datapath opcodes,
// sequencer states and default register-file indices.
package avg_seq_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_COPY = 2'b01,
        OP_LOAD = 2'b10,
        OP_ADD  = 2'b11
    } op_t;

    typedef enum logic [3:0] {
        IDLE,
        SHIFT3,
        SHIFT2,
        SHIFT1,
        LOAD,
        SUM1,
        SUM2,
        SUM3,
        DONE
    } state_t;

    localparam logic [3:0] DEF_WIN_BASE    = 4'd1;
    localparam logic [3:0] DEF_SCRATCH_REG = 4'd9;
    localparam logic [3:0] DEF_RESULT_REG  = 4'd0;

    // Register index of window slot 'off' for channel 'ch' (4 regs per channel).
    function automatic logic [3:0] win_reg(input logic [3:0] base,
                                           input logic       ch,
                                           input logic [1:0] off);
        return 4'(base + {1'b0, ch, 2'b00} + {2'b00, off});
    endfunction

endpackage

// File: rtl/dual_avg_sequencer_if.sv
// Sequencer <-> shared averaging datapath connection.
// master: sequencer side (drives op/regs/select/count), slave: datapath side.
interface dual_avg_sequencer_if;

    avg_seq_pkg::op_t op;
    logic [3:0]       src1;
    logic [3:0]       src2;
    logic [3:0]       dest;
    logic             sample_sel;
    logic             cnt_up;
    logic             overflow;

    modport master (
        output op, src1, src2, dest, sample_sel, cnt_up,
        input  overflow
    );

    modport slave (
        input  op, src1, src2, dest, sample_sel, cnt_up,
        output overflow
    );

endinterface

// File: rtl/dual_avg_sequencer_dr_capture.sv
// Per-channel data_ready capture: rising-edge detect, one-deep pending flag,
// and an overrun pulse for an edge that lands on an already-pending request.
// Optional feature macro: OVERRUN_ERR_EN (overrun pulse is tied low when undefined).
module dr_capture (
    input  logic clk,
    input  logic reset,
    input  logic dr,
    input  logic grant,
    output logic pending,
    output logic overrun
);

    logic dr_q;
    logic rise;

    // dr_q resets low so a level already high at reset release counts as an edge.
    assign rise = dr & ~dr_q;

    // Edge history and pending request; a grant and a new edge in the same
    // cycle consume the old request and leave the new one pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            dr_q    <= 1'b0;
            pending <= 1'b0;
        end else begin
            dr_q    <= dr;
            pending <= rise | (pending & ~grant);
        end
    end

`ifdef OVERRUN_ERR_EN
    assign overrun = rise & pending & ~grant;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: rtl/dual_avg_sequencer.sv
// Round-robin sequencer for the shared averaging datapath. Each grant shifts
// the channel's 4-sample window, loads the new sample and sums the window
// into RESULT_REG through SCRATCH_REG. Outputs are a Moore decode of state/cur_ch.
// Optional feature macro: OVERRUN_ERR_EN (edge on an already-pending channel
// also sets that channel's sticky err bit).
module dual_avg_sequencer
    import avg_seq_pkg::*;
#(
    parameter logic [3:0] WIN_BASE    = DEF_WIN_BASE,
    parameter logic [3:0] SCRATCH_REG = DEF_SCRATCH_REG,
    parameter logic [3:0] RESULT_REG  = DEF_RESULT_REG
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        dr0,
    input  logic                        dr1,
    dual_avg_sequencer_if.master        dp,
    output logic                        modwait,
    output logic                        result_valid,
    output logic                        result_ch,
    output logic [1:0]                  err
);

    state_t     state;
    logic       cur_ch;
    logic       last_grant;
    logic [1:0] pending;
    logic [1:0] overrun;
    logic [1:0] grant;
    logic       grant_any;
    logic       next_ch;
    logic [1:0] err_next;

    dr_capture u_cap0 (
        .clk     (clk),
        .reset   (reset),
        .dr      (dr0),
        .grant   (grant[0]),
        .pending (pending[0]),
        .overrun (overrun[0])
    );

    dr_capture u_cap1 (
        .clk     (clk),
        .reset   (reset),
        .dr      (dr1),
        .grant   (grant[1]),
        .pending (pending[1]),
        .overrun (overrun[1])
    );

    // Round-robin pick in IDLE: a lone request wins, a tie goes to ~last_grant.
    always_comb begin
        next_ch   = pending[1] & (~pending[0] | ~last_grant);
        grant_any = (state == IDLE) && (pending != 2'b00);
        grant     = {grant_any & next_ch, grant_any & ~next_ch};
    end

    // Sticky error update: SHIFT3 clears the active channel, overflow or overrun sets.
    always_comb begin
        err_next = err;
        if (state == SHIFT3)
            err_next[cur_ch] = 1'b0;
        if ((state inside {SUM1, SUM2, SUM3}) && dp.overflow)
            err_next[cur_ch] = 1'b1;
        err_next = err_next | overrun;
    end

    // Sequencer state, channel bookkeeping and error register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cur_ch     <= 1'b0;
            last_grant <= 1'b1;
            result_ch  <= 1'b0;
            err        <= '0;
        end else begin
            err <= err_next;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        cur_ch     <= next_ch;
                        last_grant <= next_ch;
                        result_ch  <= next_ch;
                        state      <= SHIFT3;
                    end
                end
                SHIFT3:  state <= SHIFT2;
                SHIFT2:  state <= SHIFT1;
                SHIFT1:  state <= LOAD;
                LOAD:    state <= SUM1;
                SUM1:    state <= SUM2;
                SUM2:    state <= SUM3;
                SUM3:    state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath command decode for the current state and channel.
    always_comb begin
        dp.op         = OP_NOP;
        dp.src1       = '0;
        dp.src2       = '0;
        dp.dest       = '0;
        dp.sample_sel = 1'b0;
        dp.cnt_up     = 1'b0;
        case (state)
            SHIFT3: begin
                dp.op   = OP_COPY;
                dp.src1 = win_reg(WIN_BASE, cur_ch, 2'd2);
                dp.dest = win_reg(WIN_BASE, cur_ch, 2'd3);
            end
            SHIFT2: begin
                dp.op   = OP_COPY;
                dp.src1 = win_reg(WIN_BASE, cur_ch, 2'd1);
                dp.dest = win_reg(WIN_BASE, cur_ch, 2'd2);
            end
            SHIFT1: begin
                dp.op   = OP_COPY;
                dp.src1 = win_reg(WIN_BASE, cur_ch, 2'd0);
                dp.dest = win_reg(WIN_BASE, cur_ch, 2'd1);
            end
            LOAD: begin
                dp.op         = OP_LOAD;
                dp.dest       = win_reg(WIN_BASE, cur_ch, 2'd0);
                dp.sample_sel = cur_ch;
                dp.cnt_up     = 1'b1;
            end
            SUM1: begin
                dp.op   = OP_ADD;
                dp.src1 = win_reg(WIN_BASE, cur_ch, 2'd0);
                dp.src2 = win_reg(WIN_BASE, cur_ch, 2'd1);
                dp.dest = SCRATCH_REG;
            end
            SUM2: begin
                dp.op   = OP_ADD;
                dp.src1 = SCRATCH_REG;
                dp.src2 = win_reg(WIN_BASE, cur_ch, 2'd2);
                dp.dest = SCRATCH_REG;
            end
            SUM3: begin
                dp.op   = OP_ADD;
                dp.src1 = SCRATCH_REG;
                dp.src2 = win_reg(WIN_BASE, cur_ch, 2'd3);
                dp.dest = RESULT_REG;
            end
            default: ;
        endcase
    end

    assign modwait      = (state != IDLE);
    assign result_valid = (state == DONE);

endmodule

// File: tb/tb_dual_avg_sequencer.sv
// Directed bench for dual_avg_sequencer with a behavioural 16x16 register-file
// datapath (unsigned carry-out as overflow). Inputs change #1 after posedge,
// outputs are sampled on negedge.
module tb_dual_avg_sequencer;
    import avg_seq_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dr0 = 1'b0;
    logic       dr1 = 1'b0;
    logic       modwait;
    logic       result_valid;
    logic       result_ch;
    logic [1:0] err;

    dual_avg_sequencer_if dp();

    dual_avg_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .dr0          (dr0),
        .dr1          (dr1),
        .dp           (dp),
        .modwait      (modwait),
        .result_valid (result_valid),
        .result_ch    (result_ch),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Datapath model
    logic [15:0] rf [16];
    logic [15:0] data0 = '0;
    logic [15:0] data1 = '0;
    logic        rf_clr = 1'b0;
    logic [16:0] add_full;

    assign add_full    = {1'b0, rf[dp.src1]} + {1'b0, rf[dp.src2]};
    assign dp.overflow = (dp.op == OP_ADD) && add_full[16];

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else begin
            case (dp.op)
                OP_COPY: rf[dp.dest] <= rf[dp.src1];
                OP_LOAD: rf[dp.dest] <= dp.sample_sel ? data1 : data0;
                OP_ADD:  rf[dp.dest] <= add_full[15:0];
                default: ;
            endcase
        end
    end

    // Event counters
    int rv_count = 0;
    int cnt_up_count = 0;
    int load_count = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (result_valid) rv_count++;
            if (dp.cnt_up) cnt_up_count++;
            if (dp.op == OP_LOAD) load_count++;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rf();
        tick();
        rf_clr = 1'b1;
        tick();
        rf_clr = 1'b0;
    endtask

    // lat = number of negedges without result_valid before the one that has it
    task automatic wait_rv(input int bound, output int lat);
        lat = 0;
        forever begin
            @(negedge clk);
            if (result_valid) break;
            lat++;
            if (lat >= bound) begin
                check("rv_timeout", 32'(result_valid), 32'd1);
                break;
            end
        end
    endtask

    function automatic logic [15:0] wsum(input logic [15:0] a, b, c, d);
        return a + b + c + d;
    endfunction

    op_t         ops [10];
    op_t         exp_ops [10];
    logic        rvs [10];
    int          lat;
    int          rv0, cu0, ld0, mw, issued, mode, nexp;
    logic [15:0] win0 [4];
    logic [15:0] win1 [4];
    logic        f_pat [9];

    initial begin
        exp_ops = '{OP_NOP, OP_NOP, OP_COPY, OP_COPY, OP_COPY,
                    OP_LOAD, OP_ADD, OP_ADD, OP_ADD, OP_NOP};
        f_pat   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        // Reset state
        reset  = 1'b1;
        rf_clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rf_clr = 1'b0;
        reset  = 1'b0;
        @(negedge clk);
        check("rst_op",       32'(dp.op),         32'(OP_NOP));
        check("rst_modwait",  32'(modwait),       32'd0);
        check("rst_rvalid",   32'(result_valid),  32'd0);
        check("rst_rch",      32'(result_ch),     32'd0);
        check("rst_err",      32'(err),           32'd0);
        check("rst_cnt_up",   32'(dp.cnt_up),     32'd0);
        check("rst_src1",     32'(dp.src1),       32'd0);
        check("rst_dest",     32'(dp.dest),       32'd0);
        check("rst_sel",      32'(dp.sample_sel), 32'd0);

        // Single ch0 sample: op trace and t+9 latency
        tick();
        data0 = 16'd100;
        dr0   = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            ops[k] = dp.op;
            rvs[k] = result_valid;
            if (k == 1) dr0 = 1'b0;
            if (k == 5) begin
                check("b_load_dest", 32'(dp.dest),       32'd1);
                check("b_load_sel",  32'(dp.sample_sel), 32'd0);
                check("b_load_cnt",  32'(dp.cnt_up),     32'd1);
            end
        end
        for (int k = 0; k < 10; k++) check($sformatf("b_op%0d", k), 32'(ops[k]), 32'(exp_ops[k]));
        check("b_rv_t8",  32'(rvs[8]),    32'd0);
        check("b_rv_t9",  32'(rvs[9]),    32'd1);
        check("b_rch",    32'(result_ch), 32'd0);
        check("b_result", 32'(rf[0]),     32'd100);
        check("b_scratch",32'(rf[9]),     32'd100);

        // Simultaneous pair after ch0 was last served: ch1 first
        tick();
        data0 = 16'd10;
        data1 = 16'd20;
        dr0   = 1'b1;
        dr1   = 1'b1;
        wait_rv(20, lat);
        check("c_lat1",  32'(lat),       32'd9);
        check("c_ch1",   32'(result_ch), 32'd1);
        check("c_res1",  32'(rf[0]),     32'd20);
        wait_rv(20, lat);
        check("c_lat2",  32'(lat),       32'd8);
        check("c_ch2",   32'(result_ch), 32'd0);
        check("c_res2",  32'(rf[0]),     32'd110);
        dr0 = 1'b0;
        dr1 = 1'b0;
        tick();

        // Reset asserted during SUM2 with ch1 pending
        tick();
        data0 = 16'd7;
        dr0   = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 1) dr0 = 1'b0;
            if (k == 3) dr1 = 1'b1;
        end
        check("g_in_sum2_op",   32'(dp.op),   32'(OP_ADD));
        check("g_in_sum2_src1", 32'(dp.src1), 32'd9);
        reset = 1'b1;
        dr1   = 1'b0;
        @(negedge clk);
        check("g_op",      32'(dp.op),        32'(OP_NOP));
        check("g_modwait", 32'(modwait),      32'd0);
        check("g_err",     32'(err),          32'd0);
        check("g_rvalid",  32'(result_valid), 32'd0);
        reset = 1'b0;
        mw = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (modwait) mw++;
        end
        check("g_no_pending", 32'(mw), 32'd0);

        // Simultaneous pair after reset: ch0 first, ch1 one cycle after DONE
        clear_rf();
        data0 = 16'd1;
        data1 = 16'd2;
        dr0   = 1'b1;
        dr1   = 1'b1;
        wait_rv(20, lat);
        check("d_lat1", 32'(lat),       32'd9);
        check("d_ch1",  32'(result_ch), 32'd0);
        check("d_res1", 32'(rf[0]),     32'd1);
        @(negedge clk);
        check("d_idle_gap", 32'(modwait), 32'd0);
        wait_rv(20, lat);
        check("d_lat2", 32'(lat),       32'd7);
        check("d_ch2",  32'(result_ch), 32'd1);
        check("d_res2", 32'(rf[0]),     32'd2);
        dr0 = 1'b0;
        dr1 = 1'b0;

        // ch1 overflow and err clear on the next ch1 sample
        clear_rf();
        for (int i = 1; i <= 5; i++) begin
            data1 = (i == 5) ? 16'h0000 : 16'h4000;
            tick();
            dr1 = 1'b1;
            wait_rv(20, lat);
            dr1 = 1'b0;
            if (i == 3) begin
                check("e_res3", 32'(rf[0]), 32'h0000_C000);
                check("e_err3", 32'(err),   32'd0);
            end
            if (i == 4) begin
                check("e_res4", 32'(rf[0]), 32'd0);
                check("e_err4", 32'(err),   32'd2);
            end
            if (i == 5) begin
                check("e_res5", 32'(rf[0]), 32'h0000_C000);
                check("e_err5", 32'(err),   32'd0);
            end
        end
        tick();

        // Three ch0 edges while busy: one extra sequence
        data0 = 16'd5;
        rv0   = rv_count;
        for (int k = 0; k < 9; k++) begin
            if (k != 0) tick();
            dr0 = f_pat[k];
        end
        wait_rv(20, lat);
`ifdef OVERRUN_ERR_EN
        check("f_err_overrun", 32'(err), 32'd1);
`else
        check("f_err_overrun", 32'(err), 32'd0);
`endif
        repeat (25) tick();
        check("f_seq_count", 32'(rv_count - rv0), 32'd2);

        // Random samples on both channels
        clear_rf();
        for (int i = 0; i < 4; i++) begin
            win0[i] = '0;
            win1[i] = '0;
        end
        cu0    = cnt_up_count;
        ld0    = load_count;
        issued = 0;
        while (issued < 1000) begin
            mode = $urandom_range(0, 2);
            tick();
            if (mode != 1) begin
                data0 = 16'($urandom);
                win0[3] = win0[2]; win0[2] = win0[1]; win0[1] = win0[0]; win0[0] = data0;
                dr0 = 1'b1;
                issued++;
            end
            if (mode != 0) begin
                data1 = 16'($urandom);
                win1[3] = win1[2]; win1[2] = win1[1]; win1[1] = win1[0]; win1[0] = data1;
                dr1 = 1'b1;
                issued++;
            end
            nexp = (mode == 2) ? 2 : 1;
            for (int j = 0; j < nexp; j++) begin
                wait_rv(30, lat);
                check("h_sum", 32'(rf[0]),
                      32'(result_ch ? wsum(win1[0], win1[1], win1[2], win1[3])
                                    : wsum(win0[0], win0[1], win0[2], win0[3])));
            end
            dr0 = 1'b0;
            dr1 = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
        end
        tick();
        check("h_cnt_up", 32'(cnt_up_count - cu0), 32'(issued));
        check("h_loads",  32'(load_count - ld0),   32'(issued));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
